// File: rtl/cordic_vector_post.sv
// Post-processing for a vectoring-mode CORDIC: removes the CORDIC gain from X,
// converts the Z angle to a 16-bit binary-angle phase and queues results in a small FIFO.
module cordic_vector_post #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [15:0]              X_i,
    input  logic [15:0]              Z_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              mag_o,
    output logic [15:0]              phase_o,
    output logic                     neg_err_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int ENT_W  = 2 * DATA_W + 1;

    localparam logic signed [COEF_W-1:0] GAIN_COEF  = 16'sh26DD;
    localparam logic signed [COEF_W-1:0] ANGLE_COEF = 16'sh517D;
    localparam logic signed [PROD_W-1:0] HALF_LSB   = 32'sh0000_2000;

    // Round-half-up of a Q*.28 product back to Q*.14, truncated to DATA_W bits.
    function automatic logic [DATA_W-1:0] round_q14(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] s;
        s = p + HALF_LSB;
        return DATA_W'(s >>> 14);
    endfunction

    // A vectoring CORDIC should never yield negative X; treat it as a fault and clamp.
    function automatic logic [DATA_W-1:0] clamp_mag(input logic signed [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0]        rounded);
        return x[DATA_W-1] ? '0 : rounded;
    endfunction

    logic                     vld_p1;
    logic signed [DATA_W-1:0] x_p1;
    logic signed [DATA_W-1:0] z_p1;

    logic                     vld_p2;
    logic [DATA_W-1:0]        mag_p2;
    logic [DATA_W-1:0]        phase_p2;
    logic                     neg_p2;

    logic signed [PROD_W-1:0] gain_prod;
    logic signed [PROD_W-1:0] angle_prod;

    // ---- S1: input capture ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        x_p1 <= X_i;
        z_p1 <= Z_i;
    end

    // ---- S2: gain compensation and radian-to-binary-angle conversion ----
    always_comb begin
        gain_prod  = PROD_W'(x_p1) * PROD_W'(GAIN_COEF);
        angle_prod = PROD_W'(z_p1) * PROD_W'(ANGLE_COEF);
    end

    always_ff @(posedge clk) begin
        mag_p2   <= clamp_mag(x_p1, round_q14(gain_prod));
        phase_p2 <= round_q14(angle_prod);
        neg_p2   <= x_p1[DATA_W-1];
    end

    // ---- S3: output FIFO ----
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;

    always_comb begin
        level = wr_ptr - rd_ptr;
        full  = (level == (AW+1)'(DEPTH));
        pop   = out_valid & out_ready;
        // When full, a same-cycle pop frees the slot the new entry lands in.
        push  = vld_p2 & (~full | out_ready);
        drop  = vld_p2 & full & ~out_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) ovf_o  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {neg_p2, phase_p2, mag_p2};
    end

    // Head fields are gated so outputs read as zero whenever the FIFO is empty.
    always_comb begin
        head      = mem[rd_ptr[AW-1:0]];
        out_valid = (level != '0);
        level_o   = level;
        mag_o     = out_valid ? head[DATA_W-1:0]          : '0;
        phase_o   = out_valid ? head[2*DATA_W-1:DATA_W]   : '0;
        neg_err_o = out_valid ? head[ENT_W-1]             : 1'b0;
    end

endmodule

// File: tb/tb_cordic_vector_post.sv
// Self-checking bench for cordic_vector_post: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a queue-based model.
module tb_cordic_vector_post;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] x_in;
    logic [15:0] z_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mag_o;
    logic [15:0] phase_o;
    logic        neg_err_o;
    logic [2:0]  level_o;
    logic        ovf_o;

    always #5 clk = ~clk;

    cordic_vector_post #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .X_i       (x_in),
        .Z_i       (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_o     (mag_o),
        .phase_o   (phase_o),
        .neg_err_o (neg_err_o),
        .level_o   (level_o),
        .ovf_o     (ovf_o)
    );

    typedef struct {
        logic [15:0] mag;
        logic [15:0] phase;
        logic        neg;
    } ent_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] z;
        logic [15:0] mag;
        logic [15:0] phase;
        logic        neg;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: results queue plus the two-edge input-to-write latency.
    ent_t model_q[$];
    logic fl_v[2];
    ent_t fl_d[2];
    logic m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Magnitude = X*K rounded; phase = floor(Z*4/pi*2^13/2^13 + 0.5) wrapped to 16 bits.
    function automatic ent_t ref_entry(input logic [15:0] x, input logic [15:0] z);
        ent_t        e;
        int          xi;
        int          zi;
        real         r;
        logic [31:0] t;
        xi = int'($signed(x));
        zi = int'($signed(z));
        if (xi < 0) begin
            e.mag = 16'h0000;
            e.neg = 1'b1;
        end else begin
            t     = 32'((xi * 9949 + 8192) / 16384);
            e.mag = t[15:0];
            e.neg = 1'b0;
        end
        r       = $floor((real'(zi) * 20861.0 + 8192.0) / 16384.0);
        t       = 32'(int'(r));
        e.phase = t[15:0];
        return e;
    endfunction

    task automatic model_clear();
        model_q.delete();
        fl_v[0] = 1'b0;
        fl_v[1] = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic iv, input logic [15:0] xs, input logic [15:0] zs,
                              input logic rdy);
        int sz;
        if (!reset) begin
            model_clear();
            return;
        end
        sz = model_q.size();
        if (sz > 0 && rdy) void'(model_q.pop_front());
        if (fl_v[1]) begin
            if (sz < DEPTH || rdy) model_q.push_back(fl_d[1]);
            else                   m_ovf = 1'b1;
        end
        fl_v[1] = fl_v[0];
        fl_d[1] = fl_d[0];
        fl_v[0] = iv;
        fl_d[0] = ref_entry(xs, zs);
    endtask

    task automatic compare_model();
        check("model_out_valid", out_valid, model_q.size() > 0);
        check("model_level", level_o, model_q.size());
        check("model_ovf", ovf_o, m_ovf);
        if (model_q.size() > 0) begin
            check("model_mag", mag_o, model_q[0].mag);
            check("model_phase", phase_o, model_q[0].phase);
            check("model_neg_err", neg_err_o, model_q[0].neg);
        end
    endtask

    task automatic tick();
        logic        iv;
        logic        rdy;
        logic [15:0] xs;
        logic [15:0] zs;
        iv  = in_valid;
        rdy = out_ready;
        xs  = x_in;
        zs  = z_in;
        @(posedge clk);
        model_step(iv, xs, zs, rdy);
        #1;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_level"}, level_o, 0);
        check({tag, "_ovf"}, ovf_o, 0);
        check({tag, "_mag"}, mag_o, 0);
        check({tag, "_phase"}, phase_o, 0);
        check({tag, "_neg_err"}, neg_err_o, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check_zero("reset");
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        vec_t vecs[7];
        ent_t e;
        logic [15:0] bp_x[6];

        vecs[0] = '{16'h6965, 16'h1922, 16'h4000, 16'h2000, 1'b0};
        vecs[1] = '{16'h6965, 16'h6488, 16'h4000, 16'h8000, 1'b0};
        vecs[2] = '{16'h6965, 16'h9B78, 16'h4000, 16'h8000, 1'b0};
        vecs[3] = '{16'h6965, 16'hB49A, 16'h4000, 16'hA000, 1'b0};
        vecs[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0000, 16'h4DB9, 16'h0000, 1'b0};
        vecs[6] = '{16'h4000, 16'h8000, 16'h26DD, 16'h5D06, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        z_in      = '0;
        model_clear();
        #2;

        // Reset held with random inputs: every output stays zero.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x_in     = 16'($urandom);
            z_in     = 16'($urandom);
            tick();
            check_zero("reset_hold");
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("idle_out_valid", out_valid, 0);

        // Directed single-result vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            x_in     = vecs[i].x;
            z_in     = vecs[i].z;
            tick();
            in_valid = 1'b0;
            tick();
            check("vec_not_early", out_valid, 0);
            tick();
            check("vec_out_valid", out_valid, 1);
            check("vec_mag", mag_o, vecs[i].mag);
            check("vec_phase", phase_o, vecs[i].phase);
            check("vec_neg_err", neg_err_o, vecs[i].neg);
            tick();
            check("vec_popped", out_valid, 0);
        end

        // Backpressure: six results into a four-entry FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bp_x[k]  = 16'(16'h1000 * (k + 1));
            in_valid = 1'b1;
            x_in     = bp_x[k];
            z_in     = 16'(16'h0400 * k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_level", level_o, 4);
        check("bp_ovf", ovf_o, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = ref_entry(bp_x[k], 16'(16'h0400 * k));
            check("bp_drain_mag", mag_o, e.mag);
            check("bp_drain_phase", phase_o, e.phase);
            tick();
        end
        check("bp_empty_level", level_o, 0);
        check("bp_ovf_sticky", ovf_o, 1);

        // Full FIFO with a simultaneous pop and push: nothing dropped.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            x_in     = 16'(16'h0800 * (k + 1));
            z_in     = 16'(16'h1100 * k);
            tick();
            if (k == 3) in_valid = 1'b0;
            if (k == 3) begin
                tick();
                tick();
                check("full_level", level_o, 4);
                in_valid = 1'b1;
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        check("full_pop_push_level", level_o, 4);
        check("full_pop_push_ovf", ovf_o, 0);
        out_ready = 1'b0;

        // Reset mid-stream with results in flight and queued.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x_in = 16'($urandom);
            z_in = 16'($urandom);
            tick();
        end
        reset = 1'b0;
        #1;
        model_clear();
        check_zero("mid_reset");
        tick();
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("post_reset_quiet", out_valid, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x_in      = 16'($urandom);
            z_in      = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
